// File: rtl/param_reg_file.sv
// Multi-port register file with one-cycle write-first reads, a PC-aliased index and a PC redirect output.
// Optional per-register busy scoreboard, enabled by defining REG_FILE_SCOREBOARD_EN.
module param_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    parameter int PC_IDX   = 15,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    input  logic                       wr0_en_i,
    input  logic [ADDR_W-1:0]          wr0_addr_i,
    input  logic [DATA_W-1:0]          wr0_data_i,
    input  logic                       wr1_en_i,
    input  logic [ADDR_W-1:0]          wr1_addr_i,
    input  logic [DATA_W-1:0]          wr1_data_i,
`ifdef REG_FILE_SCOREBOARD_EN
    input  logic                       claim_en_i,
    input  logic [ADDR_W-1:0]          claim_addr_i,
    output logic [NUM_REGS-1:0]        busy_o,
`endif
    input  logic [DATA_W-1:0]          pc_i,
    output logic [DATA_W-1:0]          pc_o,
    output logic                       pc_wr_o,
    output logic [DATA_W-1:0]          pc_wr_data_o
);

    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic                     wr0_hit_pc;
    logic                     wr1_hit_pc;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NUM_REGS);
    endfunction

    // Write enables are single-cycle qualifiers: a write commits at the edge where its enable is high.
    assign wr0_hit_pc = wr0_en_i && (wr0_addr_i == PC_A);
    assign wr1_hit_pc = wr1_en_i && (wr1_addr_i == PC_A);

    // Same-edge writes are forwarded so reads never see stale data; wr1 wins over wr0.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr_i[k*ADDR_W +: ADDR_W] == PC_A) begin
                rd_data_d[k*DATA_W +: DATA_W] = pc_i + DATA_W'(8);
            end else if (!in_range(rd_addr_i[k*ADDR_W +: ADDR_W])) begin
                rd_data_d[k*DATA_W +: DATA_W] = '0;
            end else if (wr1_en_i && (wr1_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W])) begin
                rd_data_d[k*DATA_W +: DATA_W] = wr1_data_i;
            end else if (wr0_en_i && (wr0_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W])) begin
                rd_data_d[k*DATA_W +: DATA_W] = wr0_data_i;
            end else begin
                rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_o    <= '0;
            pc_o         <= '0;
            pc_wr_o      <= 1'b0;
            pc_wr_data_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i != PC_IDX) begin
                    if (wr1_en_i && (wr1_addr_i == ADDR_W'(i))) begin
                        regs_q[i] <= wr1_data_i;
                    end else if (wr0_en_i && (wr0_addr_i == ADDR_W'(i))) begin
                        regs_q[i] <= wr0_data_i;
                    end
                end
            end
            rd_data_o <= rd_data_d;
            pc_o      <= pc_i;
            // The PC index is never stored; a write to it becomes a redirect pulse instead.
            pc_wr_o   <= wr0_hit_pc || wr1_hit_pc;
            if (wr1_hit_pc) begin
                pc_wr_data_o <= wr1_data_i;
            end else if (wr0_hit_pc) begin
                pc_wr_data_o <= wr0_data_i;
            end
        end
    end

`ifdef REG_FILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;

    // A claim beats a same-cycle write so the newer producer keeps the register reserved.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PC_IDX) begin
                    busy_q[i] <= 1'b0;
                end else if (claim_en_i && (claim_addr_i == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if ((wr0_en_i && (wr0_addr_i == ADDR_W'(i))) ||
                             (wr1_en_i && (wr1_addr_i == ADDR_W'(i)))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;
`endif

endmodule

// File: tb/tb_param_reg_file.sv
// Randomized scoreboard bench for param_reg_file; expected responses come from an array-based model.
// Define REG_FILE_SCOREBOARD_EN to also check the busy scoreboard.
`timescale 1ns/1ps
module tb_param_reg_file;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int NUM_RD   = 3;
    localparam int PC_IDX   = 15;
    localparam int ADDR_W   = 4;
    localparam int EXP_W    = NUM_REGS + DATA_W + 1 + DATA_W + NUM_RD*DATA_W;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en, wr1_en;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic [NUM_REGS-1:0]      busy;
    logic [DATA_W-1:0]        pc_in, pc_out, pc_wr_data;
    logic                     pc_wr;

    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] mdl_mem [NUM_REGS];
    logic [DATA_W-1:0] mdl_pcwd;
    logic [NUM_REGS-1:0] mdl_busy;
    int n_pass;
    int n_total;

    param_reg_file dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .wr0_en_i     (wr0_en),
        .wr0_addr_i   (wr0_addr),
        .wr0_data_i   (wr0_data),
        .wr1_en_i     (wr1_en),
        .wr1_addr_i   (wr1_addr),
        .wr1_data_i   (wr1_data),
`ifdef REG_FILE_SCOREBOARD_EN
        .claim_en_i   (claim_en),
        .claim_addr_i (claim_addr),
        .busy_o       (busy),
`endif
        .pc_i         (pc_in),
        .pc_o         (pc_out),
        .pc_wr_o      (pc_wr),
        .pc_wr_data_o (pc_wr_data)
    );

`ifndef REG_FILE_SCOREBOARD_EN
    assign busy = '0;
`endif

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NUM_RD*ADDR_W-1:0] rd3(input logic [ADDR_W-1:0] a0,
                                                     input logic [ADDR_W-1:0] a1,
                                                     input logic [ADDR_W-1:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return ADDR_W'(PC_IDX);
        return ADDR_W'($urandom_range(0, 7));
    endfunction

    // driver: applies one cycle of stimulus and pushes the model's view of the following cycle
    task automatic drive(input logic rst, input logic w0e, input logic [ADDR_W-1:0] w0a,
                         input logic [DATA_W-1:0] w0d, input logic w1e,
                         input logic [ADDR_W-1:0] w1a, input logic [DATA_W-1:0] w1d,
                         input logic [NUM_RD*ADDR_W-1:0] ra, input logic [DATA_W-1:0] pc,
                         input logic ce, input logic [ADDR_W-1:0] ca);
        logic                     pcw;
        logic                     we;
        logic [ADDR_W-1:0]        wa;
        logic [DATA_W-1:0]        wd;
        logic [ADDR_W-1:0]        a;
        logic [NUM_RD*DATA_W-1:0] rdv;
        @(negedge clk);
        rst_n = rst; wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
        wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
        rd_addr = ra; pc_in = pc; claim_en = ce; claim_addr = ca;
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) mdl_mem[i] = '0;
            mdl_pcwd = '0;
            mdl_busy = '0;
            exp_q.push_back('0);
        end else begin
            pcw = 1'b0;
            // wr0 applied first so a colliding wr1 overwrites it
            for (int p = 0; p < 2; p++) begin
                we = (p == 0) ? w0e : w1e;
                wa = (p == 0) ? w0a : w1a;
                wd = (p == 0) ? w0d : w1d;
                if (we) begin
                    if (int'(wa) == PC_IDX) begin
                        pcw = 1'b1;
                        mdl_pcwd = wd;
                    end else begin
                        mdl_mem[wa] = wd;
                    end
                    mdl_busy[wa] = 1'b0;
                end
            end
            if (ce) mdl_busy[ca] = 1'b1;
            mdl_busy[PC_IDX] = 1'b0;
            for (int k = 0; k < NUM_RD; k++) begin
                a = ra[k*ADDR_W +: ADDR_W];
                rdv[k*DATA_W +: DATA_W] = (int'(a) == PC_IDX) ? pc + 32'd8 : mdl_mem[a];
            end
            exp_q.push_back({mdl_busy, mdl_pcwd, pcw, pc, rdv});
        end
    endtask

    task automatic idle(input logic [NUM_RD*ADDR_W-1:0] ra, input logic [DATA_W-1:0] pc);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, ra, pc, 1'b0, '0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // scoreboard monitor
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < NUM_RD; k++) begin
                    chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DATA_W +: DATA_W]),
                        64'(e[k*DATA_W +: DATA_W]));
                end
                chk("pc_o", 64'(pc_out), 64'(e[NUM_RD*DATA_W +: DATA_W]));
                chk("pc_wr_o", 64'(pc_wr), 64'(e[NUM_RD*DATA_W + DATA_W]));
                chk("pc_wr_data_o", 64'(pc_wr_data), 64'(e[NUM_RD*DATA_W + DATA_W + 1 +: DATA_W]));
`ifdef REG_FILE_SCOREBOARD_EN
                chk("busy_o", 64'(busy), 64'(e[EXP_W-NUM_REGS +: NUM_REGS]));
`endif
            end
        end
    end

    initial begin
        int guard;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; wr0_addr = '0; wr1_addr = '0;
        wr0_data = '0; wr1_data = '0; rd_addr = '0; pc_in = '0; claim_en = 1'b0; claim_addr = '0;

        // reset with a write to r7 that must be dropped
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, rd3(7, 15, 0), 32'h100, 1'b0, '0);
        drive(1'b0, 1'b1, 4'd7, 32'h55, 1'b0, '0, '0, rd3(7, 7, 15), 32'h200, 1'b1, 4'd7);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 32'h55, rd3(7, 3, 15), 32'h300, 1'b0, '0);
        idle(rd3(7, 3, 5), 32'h0);
        // write-first forwarding
        drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0, rd3(3, 1, 2), 32'h0, 1'b0, '0);
        idle(rd3(3, 3, 3), 32'h4);
        // wr0/wr1 collision
        drive(1'b1, 1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, rd3(5, 5, 3), 32'h8, 1'b0, '0);
        idle(rd3(5, 5, 5), 32'hC);
        // PC reads and wrap
        idle(rd3(15, 15, 15), 32'h100);
        idle(rd3(15, 5, 15), 32'hFFFF_FFFC);
        // PC write via wr1 then idle cycles where pc_wr_data must hold
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd15, 32'h2000, rd3(15, 3, 5), 32'h40, 1'b0, '0);
        idle(rd3(15, 15, 15), 32'h44);
        idle(rd3(15, 3, 5), 32'h48);
        drive(1'b1, 1'b1, 4'd15, 32'hAAAA, 1'b1, 4'd15, 32'hBBBB, rd3(15, 0, 0), 32'h4C, 1'b0, '0);
        idle(rd3(15, 5, 3), 32'h50);
        // busy scoreboard: claim, claim+write, write
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, rd3(4, 4, 4), 32'h0, 1'b1, 4'd4);
        idle(rd3(4, 0, 0), 32'h0);
        drive(1'b1, 1'b1, 4'd4, 32'h77, 1'b0, '0, '0, rd3(4, 4, 0), 32'h0, 1'b1, 4'd4);
        idle(rd3(4, 0, 0), 32'h0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd4, 32'h78, rd3(4, 0, 0), 32'h0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, rd3(4, 0, 0), 32'h0, 1'b1, 4'd15);
        idle(rd3(4, 15, 0), 32'h0);

        // randomized traffic with occasional mid-run resets
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 1) == 1), rand_addr(), $urandom,
                  ($urandom_range(0, 1) == 1), rand_addr(), $urandom,
                  rd3(rand_addr(), rand_addr(), rand_addr()),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom,
                  ($urandom_range(0, 2) == 0), rand_addr());
        end
        idle(rd3(0, 1, 2), 32'h0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
